// File: rtl/ddr3_rx_dq_delay_trainer.sv
// Read-path DQ delay trainer for one DDR3 input IOD lane: sweeps the input delay
// line, finds the first passing window of the training pattern, centres the tap.
module ddr3_rx_dq_delay_trainer #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] PATTERN    = 8'hA5,
  parameter int                TAP_W      = 7,
  parameter int                MAX_TAPS   = 128,
  parameter int                SETTLE_CYC = 8,
  parameter int                SAMPLE_CNT = 16
) (
  input  logic              fab_clk,
  input  logic              arst_n,
  input  logic              train_start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              delay_line_out_of_range,
  output logic              delay_line_load,
  output logic              delay_line_move,
  output logic              delay_line_direction,
  output logic              train_busy,
  output logic              train_done,
  output logic              train_err,
  output logic [TAP_W-1:0]  tap_pos,
  output logic [TAP_W-1:0]  win_start,
  output logic [TAP_W-1:0]  win_end
);

  // state  | meaning
  // IDLE   | waiting for train_start
  // LOAD   | reload delay line to tap 0
  // SETTLE | wait after load/move
  // SAMPLE | compare SAMPLE_CNT words against PATTERN
  // EVAL   | update window, decide step/centre/error
  // STEP   | one increment move
  // CENTER | walk back to window centre, then settle
  // DONE   | trained, window valid
  // ERR    | no passing tap found
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_CENTER, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {C_ENTRY, C_PULSE, C_GAP, C_WAIT} cphase_t;

  localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(MAX_TAPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LD  = CNT_W'(SAMPLE_CNT - 1);

  state_t           state, state_nx;
  cphase_t          cphase, cphase_nx;
  logic [CNT_W-1:0] cnt;
  logic             pass_acc;
  logic             found_start;
  logic             dir;
  logic             at_end;
  logic [TAP_W-1:0] target;

  // window sum carried at TAP_W+1 bits so the midpoint never wraps
  assign target = TAP_W'(({1'b0, win_start} + {1'b0, win_end}) >> 1);
  assign at_end = (tap_pos == LAST_TAP) || delay_line_out_of_range;

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= S_IDLE;
      cphase <= C_ENTRY;
    end else begin
      state  <= state_nx;
      cphase <= cphase_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cphase_nx       = cphase;
    delay_line_load = 1'b0;
    delay_line_move = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (train_start) state_nx = S_LOAD;
      S_LOAD: begin
        delay_line_load = 1'b1;
        state_nx        = S_SETTLE;
      end
      S_SETTLE: if (cnt == '0) state_nx = S_SAMPLE;
      S_SAMPLE: if (cnt == '0) state_nx = S_EVAL;
      S_EVAL: begin
        cphase_nx = C_ENTRY;
        if (!pass_acc && found_start)  state_nx = S_CENTER;
        else if (at_end)               state_nx = (found_start || pass_acc) ? S_CENTER : S_ERR;
        else                           state_nx = S_STEP;
      end
      S_STEP: begin
        delay_line_move = 1'b1;
        state_nx        = S_SETTLE;
      end
      S_CENTER: begin
        case (cphase)
          C_ENTRY: cphase_nx = (tap_pos == target) ? C_WAIT : C_PULSE;
          C_PULSE: begin
            delay_line_move = 1'b1;
            cphase_nx       = C_GAP;
          end
          C_GAP:   cphase_nx = (tap_pos == target) ? C_WAIT : C_PULSE;
          default: if (cnt == '0) state_nx = S_DONE;
        endcase
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt         <= '0;
      pass_acc    <= 1'b0;
      found_start <= 1'b0;
      dir         <= 1'b0;
      tap_pos     <= '0;
      win_start   <= '0;
      win_end     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (train_start) begin
            win_start   <= '0;
            win_end     <= '0;
            found_start <= 1'b0;
          end
        end
        S_LOAD: begin
          tap_pos <= '0;
          dir     <= 1'b1;
          cnt     <= SETTLE_LD;
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            cnt      <= SAMPLE_LD;
            pass_acc <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          pass_acc <= pass_acc & (rx_data == PATTERN);
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_EVAL: begin
          if (pass_acc) begin
            if (!found_start) begin
              win_start   <= tap_pos;
              found_start <= 1'b1;
            end
            win_end <= tap_pos;
          end
          // flip direction a cycle ahead of the first decrement pulse
          if (state_nx == S_CENTER) dir <= 1'b0;
        end
        S_STEP: begin
          tap_pos <= tap_pos + TAP_W'(1);
          cnt     <= SETTLE_LD;
        end
        S_CENTER: begin
          case (cphase)
            C_ENTRY: cnt     <= SETTLE_LD;
            C_PULSE: tap_pos <= tap_pos - TAP_W'(1);
            C_GAP:   cnt     <= SETTLE_LD;
            default: if (cnt != '0) cnt <= cnt - CNT_W'(1);
          endcase
        end
        default: ;
      endcase
    end
  end

  assign delay_line_direction = dir;
  assign train_busy = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign train_done = (state == S_DONE);
  assign train_err  = (state == S_ERR);

endmodule

// File: tb/tb_ddr3_rx_dq_delay_trainer.sv
// Bench for ddr3_rx_dq_delay_trainer: IOD delay-line model driving RX data from
// the modelled tap, and a window-search reference model predicting results.
module tb_ddr3_rx_dq_delay_trainer;

  localparam logic [7:0] PAT = 8'hA5;

  logic       fab_clk = 1'b0;
  logic       arst_n;
  logic       train_start;
  logic [7:0] rx_data;
  logic       delay_line_out_of_range;
  logic       delay_line_load, delay_line_move, delay_line_direction;
  logic       train_busy, train_done, train_err;
  logic [6:0] tap_pos, win_start, win_end;

  ddr3_rx_dq_delay_trainer dut (
    .fab_clk                 (fab_clk),
    .arst_n                  (arst_n),
    .train_start             (train_start),
    .rx_data                 (rx_data),
    .delay_line_out_of_range (delay_line_out_of_range),
    .delay_line_load         (delay_line_load),
    .delay_line_move         (delay_line_move),
    .delay_line_direction    (delay_line_direction),
    .train_busy              (train_busy),
    .train_done              (train_done),
    .train_err               (train_err),
    .tap_pos                 (tap_pos),
    .win_start               (win_start),
    .win_end                 (win_end)
  );

  always #5 fab_clk = ~fab_clk;

  int errors = 0;
  int checks = 0;

  // scenario: taps s_lo..s_hi carry the pattern, s_oor raises out-of-range,
  // s_cor gets one corrupted word inside its sample window (-1 = none)
  int s_lo = 200, s_hi = 0, s_oor = -1, s_cor = -1;

  int  mtap = 0, since = 0, inc_cnt = 0, dec_cnt = 0, viol = 0;
  logic prev_move = 1'b0, prev_dir = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] non_pattern();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == PAT) v = 8'h5A;
    return v;
  endfunction

  // IOD delay line + data source, plus move/load protocol observation
  always @(negedge fab_clk) begin
    if (delay_line_load) begin
      mtap  = 0;
      since = 0;
    end else if (delay_line_move) begin
      if (delay_line_direction) begin mtap = mtap + 1; inc_cnt++; end
      else                      begin mtap = mtap - 1; dec_cnt++; end
      since = 0;
    end else begin
      since++;
    end
    if (delay_line_move && prev_move) viol++;
    if (delay_line_move && delay_line_load) viol++;
    if (delay_line_move && (delay_line_direction != prev_dir)) viol++;
    if (mtap < 0 || mtap > 127) viol++;
    prev_move = delay_line_move;
    prev_dir  = delay_line_direction;
    delay_line_out_of_range = (mtap == s_oor);
    if (mtap == s_cor && since == 12) rx_data = 8'hA4;
    else if (mtap >= s_lo && mtap <= s_hi) rx_data = PAT;
    else rx_data = non_pattern();
  end

  // Reference: walk taps upward, first contiguous passing run, stop at the
  // first fail after the run, at the top tap, or at the out-of-range tap.
  function automatic void predict(output int ws, output int we, output int last,
                                  output int fin, output int err);
    int found;
    found = 0; ws = 0; we = 0; last = 0;
    for (int t = 0; t < 128; t++) begin
      int p;
      p = (t >= s_lo && t <= s_hi && t != s_cor) ? 1 : 0;
      last = t;
      if (p == 1) begin
        if (found == 0) begin ws = t; found = 1; end
        we = t;
      end else if (found == 1) begin
        break;
      end
      if (t == 127 || t == s_oor) break;
    end
    err = (found == 0) ? 1 : 0;
    fin = (err == 1) ? last : (ws + we) / 2;
  endfunction

  task automatic run_and_check(input string tag, input bit noise);
    int ws, we, last, fin, err, got;
    predict(ws, we, last, fin, err);
    @(negedge fab_clk);
    inc_cnt = 0; dec_cnt = 0; viol = 0;
    train_start = 1'b1;
    @(negedge fab_clk);
    train_start = 1'b0;
    check({tag, " load_pulse"}, int'(delay_line_load), 1);
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge fab_clk);
      train_start = 1'b0;
      if (train_done || train_err) begin got = 1; break; end
      if (noise && (i == 200 || i == 1200 || i == 2100) && train_busy) train_start = 1'b1;
    end
    train_start = 1'b0;
    check({tag, " finished_in_time"}, got, 1);
    check({tag, " done"}, int'(train_done), 1 - err);
    check({tag, " err"}, int'(train_err), err);
    check({tag, " win_start"}, int'(win_start), ws);
    check({tag, " win_end"}, int'(win_end), we);
    check({tag, " tap_pos"}, int'(tap_pos), fin);
    check({tag, " model_tap"}, mtap, fin);
    check({tag, " inc_pulses"}, inc_cnt, last);
    check({tag, " dec_pulses"}, dec_cnt, last - fin);
    check({tag, " protocol_viol"}, viol, 0);
    check({tag, " busy"}, int'(train_busy), 0);
    repeat (6) @(negedge fab_clk);
    check({tag, " hold_tap"}, int'(tap_pos), fin);
    check({tag, " hold_state"}, int'({train_done, train_err}), err == 1 ? 1 : 2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " load"}, int'(delay_line_load), 0);
    check({tag, " move"}, int'(delay_line_move), 0);
    check({tag, " dir"}, int'(delay_line_direction), 0);
    check({tag, " busy"}, int'(train_busy), 0);
    check({tag, " done"}, int'(train_done), 0);
    check({tag, " err"}, int'(train_err), 0);
    check({tag, " tap_pos"}, int'(tap_pos), 0);
    check({tag, " win_start"}, int'(win_start), 0);
    check({tag, " win_end"}, int'(win_end), 0);
  endtask

  initial begin
    int got;
    arst_n = 1'b0;
    train_start = 1'b0;
    rx_data = 8'h00;
    delay_line_out_of_range = 1'b0;
    repeat (3) @(negedge fab_clk);
    check_all_zero("reset");
    arst_n = 1'b1;
    repeat (2) @(negedge fab_clk);

    s_lo = 10; s_hi = 20; s_oor = -1; s_cor = -1;
    run_and_check("win10_20", 1'b0);

    s_lo = 200; s_hi = 0;
    run_and_check("never", 1'b0);

    s_lo = 0; s_hi = 127;
    run_and_check("always", 1'b0);

    s_lo = 30; s_hi = 127; s_oor = 40;
    run_and_check("oor40", 1'b0);

    s_lo = 10; s_hi = 20; s_oor = -1; s_cor = 15;
    run_and_check("corrupt15", 1'b0);

    // asynchronous reset mid-sweep
    s_lo = 60; s_hi = 70; s_cor = -1;
    @(negedge fab_clk);
    train_start = 1'b1;
    @(negedge fab_clk);
    train_start = 1'b0;
    got = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge fab_clk);
      if (mtap == 50) begin got = 1; break; end
    end
    check("midreset reached_tap50", got, 1);
    repeat (5) @(negedge fab_clk);
    #2 arst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge fab_clk);
    arst_n = 1'b1;
    run_and_check("after_reset", 1'b1);

    for (int r = 0; r < 3; r++) begin
      s_lo  = int'($urandom_range(0, 110));
      s_hi  = s_lo + int'($urandom_range(0, 25));
      if (s_hi > 127) s_hi = 127;
      s_oor = ($urandom_range(0, 1) == 1) ? s_lo + int'($urandom_range(0, 12)) : -1;
      s_cor = ($urandom_range(0, 1) == 1) ? s_lo + int'($urandom_range(1, 10)) : -1;
      run_and_check($sformatf("rand%0d", r), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
